display_scanout_ctrl: RTL
=========================

# display_scanout_ctrl

Scanout controller for the 640x480 display pipeline. Watches the display timing generator's delayed screen position and frame pulse. Schedules one framebuffer line fetch per active line into a two-entry line buffer, one line ahead of display. Also performs renderer-requested front/back framebuffer swaps on frame boundaries.

## Interface
Parameters:
- COORDINATE_WIDTH, 16, width of signed sx/sy
- ADDR_WIDTH, 20, framebuffer pixel address width
- HORIZONTAL_RES, 640, active pixels per line
- VERTICAL_RES, 480, active lines per frame
- FETCH_X, -150, signed sx value at which the next line's fetch is triggered
- FB0_BASE, 0, pixel address of framebuffer 0
- FB1_BASE, 307200, pixel address of framebuffer 1

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- rst_pixel  in  1  reset; synchronous, active-high
- frame  in  1  one-cycle frame-start pulse from timing generator
- sx  in  COORDINATE_WIDTH  signed horizontal position (negative in blanking)
- sy  in  COORDINATE_WIDTH  signed vertical position (negative in blanking)
- swap_req  in  1  renderer requests front/back swap (level or pulse)
- swap_ack  out  1  one-cycle pulse: swap performed
- fb_front  out  1  framebuffer currently scanned out
- fetch_valid  out  1  line fetch request
- fetch_ready  in  1  memory side accepts request
- fetch_addr  out  ADDR_WIDTH  first pixel address of line
- fetch_len  out  COORDINATE_WIDTH  pixels to fetch
- fetch_buf  out  1  line-buffer half to write
- rd_buf  out  1  line-buffer half to display on current line
- underrun  out  1  one-cycle pulse: trigger arrived while previous request still pending

## Operation
- Fetch target line L = sy+1; a fetch is triggered on the cycle where sx == FETCH_X and 0 <= L <= VERTICAL_RES-1.
- Line 0 is therefore fetched during line sy = -1. No trigger occurs for sy = VERTICAL_RES-1.
- Address is generated by an accumulator, not a multiplier:
  - on frame: line_addr <= base of (post-swap) front buffer;
  - on each trigger: fetch_addr <= line_addr, then line_addr += HORIZONTAL_RES.
- fetch_buf = L[0]; rd_buf = sy[0] registered; fetch_len = HORIZONTAL_RES.
- FSM IDLE, REQ:
  - IDLE -> REQ on trigger; fetch_valid = 1 in REQ.
  - REQ -> IDLE when fetch_valid && fetch_ready.
  - fetch_addr, fetch_len and fetch_buf are stable while in REQ.
- Trigger while in REQ:
  - the pending request is kept unchanged and the new line is skipped;
  - underrun pulses; the accumulator still advances.
- Swap:
  - swap_req sets a pending flag.
  - On frame with pending set: fb_front toggles, pending clears, swap_ack pulses.
  - swap_req on the same cycle as frame counts for that frame.
  - Multiple requests before one frame collapse into one swap.
- Reset values: state IDLE, fetch_valid 0, fetch_addr 0, fetch_buf 0, rd_buf 0, fb_front 0, swap_ack 0, underrun 0, pending 0, line_addr FB0_BASE.
- Reset mid-request drops the request; no handshake is completed.

## Timing
- fetch_valid rises on the edge after the trigger cycle; minimum accept latency is 1 cycle.
- swap_ack and the fb_front change occur on the edge after the frame cycle.
- line_addr reload uses the new fb_front value on that same edge.
- underrun is registered: it asserts one cycle after the colliding trigger.
- rd_buf lags sy by one cycle, matching the pixel pipeline register.

## Configuration
- Macro: SCANOUT_LINE_DOUBLE_EN.
- Defined:
  - source is HORIZONTAL_RES/2 x VERTICAL_RES/2; source line S = L>>1;
  - trigger only when L is even; accumulator steps HORIZONTAL_RES/2;
  - fetch_len = HORIZONTAL_RES/2; fetch_buf = S[0]; rd_buf = (sy>>1)[0].
- Undefined: full-resolution behaviour as above.

## Structure
- Put fb address typedef, FSM state enum and default resolution constants in the shared display_pkg.
- One sub-module: display_line_addr_gen, containing the accumulator, reload and step logic.

## Test plan
- Reset, free-running timing, fetch_ready tied 1 -> first fetch at sy=-1, sx=FETCH_X+1, addr 0, fetch_buf 0, len 640; line 479 addr 306560; 480 requests per frame.
- No swap_req -> fb_front stays 0 across 3 frames, swap_ack never pulses.
- swap_req pulse mid-frame -> at next frame fb_front=1, swap_ack one cycle; line 0 addr 307200, line 479 addr 613760.
- swap_req asserted exactly on frame cycle -> swap in that frame; two requests in one frame -> single swap.
- fetch_ready held 0 across two triggers -> request for line L held unchanged, underrun pulses once, next accepted request for L+2 addresses L+2.
- SCANOUT_LINE_DOUBLE_EN defined -> 240 requests per frame, len 320, line 479 display uses source addr 76480, rd_buf toggles every two lines.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display pipeline types and default 640x480 timing constants.
package display_pkg;

  localparam int unsigned DEFAULT_H_RES   = 640;
  localparam int unsigned DEFAULT_V_RES   = 480;
  localparam int          DEFAULT_FETCH_X = -150;
  localparam int unsigned DEFAULT_FB0     = 0;
  localparam int unsigned DEFAULT_FB1     = 307200;
  localparam int unsigned FB_ADDR_WIDTH   = 20;

  typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

  typedef enum logic {
    SCAN_IDLE,
    SCAN_REQ
  } scan_state_e;

endpackage

// File: rtl/display_line_addr_gen.sv
// Framebuffer line address accumulator: reloads to a base on frame start and
// advances by one source line per fetch trigger.
module display_line_addr_gen #(
  parameter int unsigned           ADDR_WIDTH = 20,
  parameter int unsigned           STEP       = 640,
  parameter logic [ADDR_WIDTH-1:0] RESET_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  input  logic [ADDR_WIDTH-1:0] reload_base,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] line_addr
);

  localparam logic [ADDR_WIDTH-1:0] STEP_W = ADDR_WIDTH'(STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr <= RESET_BASE;
    end else if (reload) begin
      line_addr <= reload_base;
    end else if (step) begin
      line_addr <= line_addr + STEP_W;
    end
  end

endmodule

// File: rtl/display_scanout_ctrl.sv
// Scanout controller: one line fetch per active line, one line ahead of display,
// plus frame-aligned front/back swaps. Option macro: SCANOUT_LINE_DOUBLE_EN.
module display_scanout_ctrl
  import display_pkg::*;
#(
  parameter int unsigned COORDINATE_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH       = FB_ADDR_WIDTH,
  parameter int unsigned HORIZONTAL_RES   = DEFAULT_H_RES,
  parameter int unsigned VERTICAL_RES     = DEFAULT_V_RES,
  parameter int          FETCH_X          = DEFAULT_FETCH_X,
  parameter int unsigned FB0_BASE         = DEFAULT_FB0,
  parameter int unsigned FB1_BASE         = DEFAULT_FB1
) (
  input  logic                               clk_pixel,
  input  logic                               rst_pixel,
  input  logic                               frame,
  input  logic signed [COORDINATE_WIDTH-1:0] sx,
  input  logic signed [COORDINATE_WIDTH-1:0] sy,
  input  logic                               swap_req,
  output logic                               swap_ack,
  output logic                               fb_front,
  output logic                               fetch_valid,
  input  logic                               fetch_ready,
  output logic [ADDR_WIDTH-1:0]              fetch_addr,
  output logic [COORDINATE_WIDTH-1:0]        fetch_len,
  output logic                               fetch_buf,
  output logic                               rd_buf,
  output logic                               underrun
);

  localparam int unsigned CW = COORDINATE_WIDTH;
`ifdef SCANOUT_LINE_DOUBLE_EN
  localparam int unsigned LINE_PIXELS = HORIZONTAL_RES / 2;
`else
  localparam int unsigned LINE_PIXELS = HORIZONTAL_RES;
`endif
  localparam logic signed [CW-1:0] FETCH_X_C = CW'(FETCH_X);
  localparam logic signed [CW-1:0] V_LAST    = CW'(VERTICAL_RES - 1);
  localparam logic signed [CW-1:0] ONE       = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] FB0_A    = ADDR_WIDTH'(FB0_BASE);
  localparam logic [ADDR_WIDTH-1:0] FB1_A    = ADDR_WIDTH'(FB1_BASE);

  scan_state_e state, state_next;

  logic signed [CW-1:0]  line_next;
  logic                  trigger;
  logic                  line_half;
  logic                  rd_half;
  logic                  swap_pending;
  logic                  swap_hit;
  logic                  front_next;
  logic [ADDR_WIDTH-1:0] line_addr;

  assign line_next = sy + ONE;

`ifdef SCANOUT_LINE_DOUBLE_EN
  // Each source line is shown twice, so only even target lines fetch.
  assign trigger   = (sx == FETCH_X_C) && !line_next[CW-1] && (line_next <= V_LAST)
                     && !line_next[0];
  assign line_half = line_next[1];
  assign rd_half   = sy[1];
`else
  assign trigger   = (sx == FETCH_X_C) && !line_next[CW-1] && (line_next <= V_LAST);
  assign line_half = line_next[0];
  assign rd_half   = sy[0];
`endif

  assign fetch_len = CW'(LINE_PIXELS);

  // A request on the frame cycle itself is folded into this frame's swap.
  assign swap_hit   = frame && (swap_pending || swap_req);
  assign front_next = fb_front ^ swap_hit;

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      swap_pending <= 1'b0;
      fb_front     <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= swap_hit;
      fb_front <= front_next;
      if (frame) begin
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  display_line_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP       (LINE_PIXELS),
    .RESET_BASE (FB0_A)
  ) u_addr_gen (
    .clk         (clk_pixel),
    .rst         (rst_pixel),
    .reload      (frame),
    .reload_base (front_next ? FB1_A : FB0_A),
    .step        (trigger),
    .line_addr   (line_addr)
  );

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      state <= SCAN_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SCAN_IDLE: if (trigger)     state_next = SCAN_REQ;
      SCAN_REQ:  if (fetch_ready) state_next = SCAN_IDLE;
      default:                    state_next = SCAN_IDLE;
    endcase
  end

  always_comb begin
    fetch_valid = (state == SCAN_REQ);
  end

  // Request fields latch only from IDLE; a trigger during REQ is dropped.
  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      fetch_addr <= '0;
      fetch_buf  <= 1'b0;
      underrun   <= 1'b0;
      rd_buf     <= 1'b0;
    end else begin
      rd_buf   <= rd_half;
      underrun <= trigger && (state == SCAN_REQ);
      if (trigger && (state == SCAN_IDLE)) begin
        fetch_addr <= line_addr;
        fetch_buf  <= line_half;
      end
    end
  end

endmodule
